// File: rtl/lift_pkg.sv
// lift_pkg
// Shared constants and types for the lift call panel and the lift core.
//   FLOORS  : number of floors / call buttons
//   FLOOR_W : width of a floor index
//   floor_t : floor index type
//   issue_state_e : request issuer states (IDLE, OFFER)
package lift_pkg;

    localparam int FLOORS  = 8;
    localparam int FLOOR_W = $clog2(FLOORS);

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic {
        IDLE,
        OFFER
    } issue_state_e;

endpackage

// File: rtl/lift_btn_debounce.sv
// lift_btn_debounce
// One call button: two-flop synchroniser followed by a debounce counter.
// Emits a single-cycle press event on each rising edge of the debounced level.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw asynchronous button level, 1 = pressed
//   press_o : one-cycle pulse after the debounced level rises
module lift_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       level_d;
    logic       levelPrev_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // A sample that differs from the debounced level is counted; once
    // DEBOUNCE_CYCLES such samples are banked, the next differing sample
    // flips the level. Any sample matching the level clears the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Synchroniser, debounce state and the delayed level for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            levelPrev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            levelPrev_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = level_q & ~levelPrev_q;

endmodule

// File: rtl/lift_call_panel.sv
// lift_call_panel
// Call-button front end for the lift controller. Debounces the floor buttons,
// latches presses as pending calls with lamps, and offers calls one at a time
// to the lift core over a valid/ready handshake.
//   clk_i            : clock
//   rst_ni           : asynchronous active-low reset
//   btn_i            : raw button levels, one per floor
//   current_floor_i  : floor reported by the lift core
//   door_i           : lift core door status, 1 = open
//   emergency_stop_i : suspends issuing while high
//   req_ready_i      : lift core accepts the offered request
//   req_valid_o      : a request is being offered
//   req_floor_o      : offered floor, meaningful while req_valid_o
//   lamp_o           : call lamp per floor, 1 = call pending
//   pending_cnt_o    : number of lit lamps
module lift_call_panel
    import lift_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [FLOORS-1:0] btn_i,
    input  floor_t            current_floor_i,
    input  logic              door_i,
    input  logic              emergency_stop_i,
    input  logic              req_ready_i,
    output logic              req_valid_o,
    output floor_t            req_floor_o,
    output logic [FLOORS-1:0] lamp_o,
    output logic [3:0]        pending_cnt_o
);

    // First set bit of cand searching upward from last+1, wrapping round.
    function automatic floor_t rrSelect(input logic [FLOORS-1:0] cand, input floor_t last);
        floor_t sel;
        logic   found;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= FLOORS; i++) begin
            floor_t idx;
            idx = floor_t'((int'(last) + i) % FLOORS);
            if (!found && cand[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [3:0] popCount(input logic [FLOORS-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < FLOORS; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    logic [FLOORS-1:0] press;
    logic [FLOORS-1:0] serviceMask;
    logic [FLOORS-1:0] candidates;
    logic [FLOORS-1:0] lamp_q;
    logic [FLOORS-1:0] lamp_d;
    logic [FLOORS-1:0] unsent_q;
    logic [FLOORS-1:0] unsent_d;
    issue_state_e      state_q;
    issue_state_e      state_d;
    floor_t            reqFloor_q;
    floor_t            reqFloor_d;
    floor_t            lastIssued_q;
    floor_t            lastIssued_d;
    logic              offerServiced;

    for (genvar g = 0; g < FLOORS; g++) begin : gen_btn
        lift_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .btn_i  (btn_i[g]),
            .press_o(press[g])
        );
    end

    // The floor whose door is open is being serviced; its call is cleared.
    always_comb begin
        serviceMask = '0;
        if (door_i) begin
            serviceMask[current_floor_i] = 1'b1;
        end
    end

    // A floor that is being serviced right now is never offered.
    assign candidates    = unsent_q & ~serviceMask;
    assign offerServiced = door_i && (current_floor_i == reqFloor_q);

    // Call bookkeeping and issuer. A press on an already-lit floor is ignored
    // so that a call already handed to the core is not sent twice. Service is
    // applied last so it overrides a simultaneous press or offer. A completed
    // handshake takes precedence over withdrawal, since the core has the call.
    always_comb begin
        state_d      = state_q;
        reqFloor_d   = reqFloor_q;
        lastIssued_d = lastIssued_q;
        unsent_d     = unsent_q | (press & ~lamp_q);
        lamp_d       = (lamp_q | press) & ~serviceMask;
        case (state_q)
            IDLE: begin
                if (!emergency_stop_i && (candidates != '0)) begin
                    reqFloor_d = rrSelect(candidates, lastIssued_q);
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (req_ready_i) begin
                    unsent_d[reqFloor_q] = 1'b0;
                    lastIssued_d         = reqFloor_q;
                    state_d              = IDLE;
                end else if (emergency_stop_i || offerServiced) begin
                    state_d = IDLE;
                end
            end
        endcase
        unsent_d = unsent_d & ~serviceMask;
    end

    // Panel state registers; lastIssued resets to the top floor so the first
    // search starts at floor 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            reqFloor_q   <= '0;
            lastIssued_q <= floor_t'(FLOORS - 1);
            lamp_q       <= '0;
            unsent_q     <= '0;
        end else begin
            state_q      <= state_d;
            reqFloor_q   <= reqFloor_d;
            lastIssued_q <= lastIssued_d;
            lamp_q       <= lamp_d;
            unsent_q     <= unsent_d;
        end
    end

    assign req_valid_o   = (state_q == OFFER);
    assign req_floor_o   = reqFloor_q;
    assign lamp_o        = lamp_q;
    assign pending_cnt_o = popCount(lamp_q);

endmodule

// File: tb/tb_lift_call_panel.sv
// tb_lift_call_panel
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the call panel kept in this bench.
module tb_lift_call_panel;
    import lift_pkg::*;

    localparam int DEB = 4;

    logic              clk;
    logic              rst_n;
    logic [FLOORS-1:0] btn;
    floor_t            curFloor;
    logic              door;
    logic              estop;
    logic              ready;
    logic              reqValid;
    floor_t            reqFloor;
    logic [FLOORS-1:0] lamp;
    logic [3:0]        pendingCnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [FLOORS-1:0] mS1, mS2, mLvl, mPrev, mLamp, mUnsent;
    int                mRun [FLOORS];
    logic              mOffer;
    int                mFloor;
    int                mLast;

    lift_call_panel #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .btn_i           (btn),
        .current_floor_i (curFloor),
        .door_i          (door),
        .emergency_stop_i(estop),
        .req_ready_i     (ready),
        .req_valid_o     (reqValid),
        .req_floor_o     (reqFloor),
        .lamp_o          (lamp),
        .pending_cnt_o   (pendingCnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mS1     = '0;
        mS2     = '0;
        mLvl    = '0;
        mPrev   = '0;
        mLamp   = '0;
        mUnsent = '0;
        mOffer  = 1'b0;
        mFloor  = 0;
        mLast   = FLOORS - 1;
        for (int f = 0; f < FLOORS; f++) mRun[f] = 0;
    endtask

    // One rising edge of the model, using the inputs as they stand before it.
    task automatic modelStep();
        logic [FLOORS-1:0] press;
        logic [FLOORS-1:0] svc;
        logic [FLOORS-1:0] cand;
        logic [FLOORS-1:0] nextUnsent;
        logic              found;
        press = mLvl & ~mPrev;
        svc   = '0;
        if (door) svc[curFloor] = 1'b1;
        mPrev = mLvl;
        // The level flips on the (DEB+1)th consecutive differing sample.
        for (int f = 0; f < FLOORS; f++) begin
            if (mS2[f] != mLvl[f]) begin
                mRun[f]++;
                if (mRun[f] > DEB) begin
                    mLvl[f] = ~mLvl[f];
                    mRun[f] = 0;
                end
            end else begin
                mRun[f] = 0;
            end
        end
        mS2 = mS1;
        mS1 = btn;
        nextUnsent = mUnsent | (press & ~mLamp);
        if (!mOffer) begin
            cand = mUnsent & ~svc;
            if (!estop && cand != '0) begin
                found = 1'b0;
                for (int k = 1; k <= FLOORS; k++) begin
                    if (!found && cand[(mLast + k) % FLOORS]) begin
                        mFloor = (mLast + k) % FLOORS;
                        found  = 1'b1;
                    end
                end
                mOffer = 1'b1;
            end
        end else if (ready) begin
            nextUnsent[mFloor] = 1'b0;
            mLast  = mFloor;
            mOffer = 1'b0;
        end else if (estop || svc[mFloor]) begin
            mOffer = 1'b0;
        end
        mUnsent = nextUnsent & ~svc;
        mLamp   = (mLamp | press) & ~svc;
    endtask

    // Advance one clock, step the model, then compare just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("valid", reqValid, mOffer);
        if (mOffer) checkOutput("floor", reqFloor, mFloor);
        checkOutput("lamp", lamp, mLamp);
        checkOutput("pend", pendingCnt, $countones(mLamp));
    endtask

    // Assert reset between edges and check that outputs clear at once.
    task automatic doReset();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", reqValid, 0);
        checkOutput("rst_floor", reqFloor, 0);
        checkOutput("rst_lamp", lamp, 0);
        checkOutput("rst_pend", pendingCnt, 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitOffer(input int budget);
        int n;
        n = 0;
        while (!reqValid && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("offer_wait", reqValid, 1);
    endtask

    logic   sawLamp5;
    logic   sawValid;
    floor_t issued [$];
    int     issueCyc [$];

    initial begin
        btn      = '0;
        curFloor = '0;
        door     = 1'b0;
        estop    = 1'b0;
        ready    = 1'b0;
        rst_n    = 1'b1;
        doReset();

        // Single press on floor 3 with the core always ready.
        btn[3] = 1'b1;
        ready  = 1'b1;
        for (int e = 0; e < 10; e++) begin
            applyStimulus();
            if (e == 6) checkOutput("t1_lamp_early", lamp, 8'h00);
            if (e == 7) checkOutput("t1_lamp", lamp, 8'h08);
            if (e == 8) begin
                checkOutput("t1_valid", reqValid, 1);
                checkOutput("t1_floor", reqFloor, 3);
                checkOutput("t1_pend", pendingCnt, 1);
            end
            if (e == 9) checkOutput("t1_valid_drop", reqValid, 0);
        end
        btn[3] = 1'b0;
        repeat (10) applyStimulus();
        curFloor = 3'd3;
        door     = 1'b1;
        applyStimulus();
        checkOutput("t1_service", lamp, 8'h00);
        door = 1'b0;

        // Bouncing button never produces a call.
        sawLamp5 = 1'b0;
        sawValid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            btn[5] = (c < 20) && ((c / 2) % 2 == 0);
            applyStimulus();
            if (lamp[5]) sawLamp5 = 1'b1;
            if (reqValid) sawValid = 1'b1;
        end
        checkOutput("bounce_lamp", sawLamp5, 0);
        checkOutput("bounce_valid", sawValid, 0);

        // Floors 1, 5, 7 together; held off, then issued round-robin.
        doReset();
        ready = 1'b0;
        btn   = 8'b1010_0010;
        repeat (9) applyStimulus();
        checkOutput("t3_valid", reqValid, 1);
        checkOutput("t3_first", reqFloor, 1);
        for (int c = 0; c < 8; c++) begin
            applyStimulus();
            checkOutput("t3_hold", {reqValid, reqFloor}, {1'b1, 3'd1});
        end
        ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (reqValid && ready) begin
                issued.push_back(reqFloor);
                issueCyc.push_back(c);
            end
            applyStimulus();
        end
        checkOutput("t3_count", issued.size(), 3);
        if (issued.size() == 3) begin
            checkOutput("t3_order0", issued[0], 1);
            checkOutput("t3_order1", issued[1], 5);
            checkOutput("t3_order2", issued[2], 7);
            checkOutput("t3_gap1", issueCyc[1] - issueCyc[0], 2);
            checkOutput("t3_gap2", issueCyc[2] - issueCyc[1], 2);
        end
        btn   = '0;
        ready = 1'b0;
        repeat (10) applyStimulus();

        // Clear all lamps, then offer floor 5 and hit emergency stop.
        door = 1'b1;
        curFloor = 3'd1; applyStimulus();
        curFloor = 3'd5; applyStimulus();
        curFloor = 3'd7; applyStimulus();
        door = 1'b0;
        checkOutput("t4_cleared", lamp, 8'h00);
        btn[5] = 1'b1;
        waitOffer(20);
        checkOutput("t4_floor", reqFloor, 5);
        estop = 1'b1;
        applyStimulus();
        checkOutput("t4_estop_drop", reqValid, 0);
        checkOutput("t4_lamp_kept", lamp[5], 1);
        applyStimulus();
        applyStimulus();
        estop = 1'b0;
        applyStimulus();
        checkOutput("t4_reoffer", {reqValid, reqFloor}, {1'b1, 3'd5});

        // Service of the offered floor with a fresh press arriving meanwhile.
        btn[5] = 1'b0;
        repeat (8) applyStimulus();
        checkOutput("t5_pend_before", pendingCnt, 1);
        btn[5]   = 1'b1;
        curFloor = 3'd5;
        door     = 1'b1;
        applyStimulus();
        checkOutput("t5_withdrawn", reqValid, 0);
        checkOutput("t5_lamp", lamp[5], 0);
        checkOutput("t5_pend", pendingCnt, 0);
        repeat (9) applyStimulus();
        checkOutput("t5_no_relight", lamp[5], 0);
        door = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("t5_no_relight_late", lamp, 8'h00);

        // Reset while an offer is outstanding.
        btn = '0;
        repeat (8) applyStimulus();
        btn[2] = 1'b1;
        waitOffer(20);
        doReset();

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            for (int f = 0; f < FLOORS; f++) begin
                if ($urandom_range(0, 39) == 0) btn[f] = ~btn[f];
            end
            if (door) begin
                if ($urandom_range(0, 2) == 0) door = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                door = 1'b1;
            end else if ($urandom_range(0, 4) == 0) begin
                curFloor = floor_t'($urandom_range(0, FLOORS - 1));
            end
            if (estop) estop = ($urandom_range(0, 2) != 0);
            else       estop = ($urandom_range(0, 49) == 0);
            ready = ($urandom_range(0, 1) == 1) && !door && !estop;
            applyStimulus();
            if (c == 1000) doReset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
